// File: rtl/vga_write_arbiter_if.sv
// Pixel-write bus between the drawing engines, the lane eraser and the arbiter.
// The arbiter takes the slave side; the engine/eraser side is the master.
interface vga_write_arbiter_if #(
  parameter int NUM_REQ = 4
);
  logic                    erase_active;
  logic [9:0]              erase_x;
  logic [8:0]              erase_y;
  logic [8:0]              erase_color;
  logic                    erase_write;
  logic [NUM_REQ-1:0]      req;
  logic [10*NUM_REQ-1:0]   req_x;
  logic [9*NUM_REQ-1:0]    req_y;
  logic [9*NUM_REQ-1:0]    req_color;
  logic [NUM_REQ-1:0]      req_write;
  logic [NUM_REQ-1:0]      gnt;
  logic [9:0]              VGA_x;
  logic [8:0]              VGA_y;
  logic [8:0]              VGA_color;
  logic                    VGA_write;
  logic                    busy;

  modport slave (
    input  erase_active, erase_x, erase_y, erase_color, erase_write,
    input  req, req_x, req_y, req_color, req_write,
    output gnt, VGA_x, VGA_y, VGA_color, VGA_write, busy
  );

  modport master (
    output erase_active, erase_x, erase_y, erase_color, erase_write,
    output req, req_x, req_y, req_color, req_write,
    input  gnt, VGA_x, VGA_y, VGA_color, VGA_write, busy
  );
endinterface

// File: rtl/vga_write_arbiter.sv
// Shares the VGA adapter write port: eraser preempts, game engines rotate
// round-robin with a per-burst hold limit; the chosen pixel is registered once.
module vga_write_arbiter #(
  parameter int         NUM_REQ   = 4,
  parameter int         MAX_BURST = 1024,
  parameter logic [8:0] BLACK     = 9'b000_000_000
) (
  input logic               Clock,
  input logic               Reset,
  vga_write_arbiter_if.slave bus
);

  localparam int OW = $clog2(NUM_REQ);
  localparam int BW = $clog2(MAX_BURST);
  localparam logic [BW-1:0] BURST_LAST = BW'(MAX_BURST - 1);

  typedef enum logic [1:0] {IDLE, GRANT, ERASE} state_t;

  state_t             state_q, state_d;
  logic [OW-1:0]      owner_q, owner_d;
  logic [OW-1:0]      ptr_q, ptr_d;
  logic [BW-1:0]      burst_cnt_q, burst_cnt_d;
  logic [NUM_REQ-1:0] gnt_reg_q, gnt_reg_d;
  logic [9:0]         vga_x_q, vga_x_d;
  logic [8:0]         vga_y_q, vga_y_d;
  logic [8:0]         vga_color_q, vga_color_d;
  logic               vga_write_q, vga_write_d;
  logic               busy_q, busy_d;

  logic [OW-1:0]      pick;
  logic               pick_vld;
  logic [NUM_REQ-1:0] others;

  function automatic logic [OW-1:0] next_idx(input logic [OW-1:0] i);
    if (int'(i) == NUM_REQ - 1) return '0;
    return i + 1'b1;
  endfunction

  // First requester at or after ptr, wrapping at NUM_REQ-1.
  always_comb begin
    logic [OW-1:0] idx;
    idx      = ptr_q;
    pick     = ptr_q;
    pick_vld = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!pick_vld && bus.req[idx]) begin
        pick     = idx;
        pick_vld = 1'b1;
      end
      idx = next_idx(idx);
    end
  end

  assign others = bus.req & ~(NUM_REQ'(1) << owner_q);

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    ptr_d       = ptr_q;
    burst_cnt_d = burst_cnt_q;
    gnt_reg_d   = gnt_reg_q;
    if (bus.erase_active) begin
      state_d     = ERASE;
      gnt_reg_d   = '0;
      burst_cnt_d = '0;
      // The preempted owner goes first once the eraser is done.
      if (state_q == GRANT) ptr_d = owner_q;
    end else begin
      case (state_q)
        IDLE: begin
          if (pick_vld) begin
            owner_d     = pick;
            gnt_reg_d   = NUM_REQ'(1) << pick;
            burst_cnt_d = '0;
            state_d     = GRANT;
          end
        end
        GRANT: begin
          if (!bus.req[owner_q] || (burst_cnt_q == BURST_LAST && |others)) begin
            gnt_reg_d = '0;
            ptr_d     = next_idx(owner_q);
            state_d   = IDLE;
          end else if (burst_cnt_q == BURST_LAST) begin
            burst_cnt_d = '0;
          end else begin
            burst_cnt_d = burst_cnt_q + 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    vga_x_d     = vga_x_q;
    vga_y_d     = vga_y_q;
    vga_color_d = BLACK;
    vga_write_d = 1'b0;
    if (bus.erase_active) begin
      vga_x_d     = bus.erase_x;
      vga_y_d     = bus.erase_y;
      vga_color_d = bus.erase_color;
      vga_write_d = bus.erase_write;
    end else if (|gnt_reg_q) begin
      vga_x_d     = bus.req_x[int'(owner_q)*10 +: 10];
      vga_y_d     = bus.req_y[int'(owner_q)*9 +: 9];
      vga_color_d = bus.req_color[int'(owner_q)*9 +: 9];
      vga_write_d = bus.req_write[owner_q];
    end
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q     <= IDLE;
      owner_q     <= '0;
      ptr_q       <= '0;
      burst_cnt_q <= '0;
      gnt_reg_q   <= '0;
      vga_x_q     <= '0;
      vga_y_q     <= '0;
      vga_color_q <= BLACK;
      vga_write_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      ptr_q       <= ptr_d;
      burst_cnt_q <= burst_cnt_d;
      gnt_reg_q   <= gnt_reg_d;
      vga_x_q     <= vga_x_d;
      vga_y_q     <= vga_y_d;
      vga_color_q <= vga_color_d;
      vga_write_q <= vga_write_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.gnt       = gnt_reg_q & {NUM_REQ{~bus.erase_active}};
  assign bus.VGA_x     = vga_x_q;
  assign bus.VGA_y     = vga_y_q;
  assign bus.VGA_color = vga_color_q;
  assign bus.VGA_write = vga_write_q;
  assign bus.busy      = busy_q;

endmodule
